l2_arbiter: RTL and testbench
=============================

L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have ports: reset_n  in  1  reset, synchronous and active-low.
REQ-003 SHALL have ports: icache_read  in  1  I-side line-fill request; icache_address  in  16  line address; icache_rdata  out  128  fill data; icache_resp  out  1  completion pulse.
REQ-004 SHALL have ports: dcache_read  in  1  and dcache_write  in  1  D-side read and writeback requests; dcache_address  in  16; dcache_wdata  in  128  writeback line; dcache_rdata  out  128; dcache_resp  out  1.
REQ-005 SHALL have ports: l2_read  out  1  and l2_write  out  1  shared-L2 commands; l2_address  out  16; l2_wdata  out  128; l2_rdata  in  128; l2_resp  in  1  L2 completion (one-cycle pulse).

Function
REQ-006 SHALL implement a 3-state FSM: IDLE, SERVE_I, SERVE_D.
REQ-007 SHALL hold a 1-bit last_grant register (I or D) for round-robin fairness.
REQ-008 In IDLE with only the I request (icache_read) high at a posedge, SHALL enter SERVE_I.
REQ-009 In IDLE with only the D request (dcache_read or dcache_write) high at a posedge, SHALL enter SERVE_D.
REQ-010 In IDLE with both requests high, SHALL grant the side not equal to last_grant.
REQ-011 On every transition out of IDLE, SHALL update last_grant to the granted side.
REQ-012 On that same transition, SHALL latch the granted side's address, op (read/write) and wdata into internal registers.
REQ-013 Arbitration latency SHALL be one cycle: for a request sampled at posedge N, l2_read or l2_write is high from cycle N+1.
REQ-014 In SERVE_x, l2_address, l2_wdata and l2_read/l2_write SHALL be driven from the latched registers only; requester changes after grant SHALL be ignored.
REQ-015 In SERVE_x, l2_read = latched op is read and l2_write = latched op is write; the two SHALL never be high together.
REQ-016 In IDLE, l2_read = l2_write = 0, l2_address = 0 and l2_wdata = 0.
REQ-017 icache_rdata and dcache_rdata SHALL pass l2_rdata through combinationally at all times.
REQ-018 icache_resp SHALL be high only when state = SERVE_I and l2_resp = 1 (combinational, same cycle).
REQ-019 dcache_resp SHALL be high only when state = SERVE_D and l2_resp = 1 (combinational, same cycle).
REQ-020 On l2_resp in SERVE_x, the FSM SHALL return to IDLE at the next posedge; there is one mandatory IDLE cycle between transactions.
REQ-021 l2_resp while in IDLE SHALL be ignored: no state change and no resp output.
REQ-022 Without l2_resp, a SERVE_x state SHALL be held indefinitely (no timeout).
REQ-023 dcache_read and dcache_write both high is illegal; if sampled at grant, it SHALL be latched as a write.
REQ-024 A requester that drops its request mid-service SHALL still receive a resp pulse when l2_resp arrives.
REQ-025 A requester that holds its request after resp SHALL be treated as a new request in the following IDLE cycle.

Reset
REQ-026 When reset_n = 0 at a posedge, SHALL set state = IDLE, last_grant = D, and clear all latched registers to 0.
REQ-027 Reset SHALL take priority over all other events, including mid-transaction and coincident with l2_resp; outputs SHALL be at IDLE values from the next cycle.
REQ-028 After reset with both requests pending, I SHALL be granted first.

Verification
REQ-029 Reset, then icache_read=1 with address 0x1230 held -> cycle+1: l2_read=1, l2_address=0x1230; l2_resp with rdata 0xA5..A5 -> icache_resp=1 and icache_rdata=0xA5..A5 in that cycle; IDLE next cycle.
REQ-030 icache_read and dcache_write (address 0x4440, wdata 0x0F..0F) high together from reset -> I served first; after its resp and one IDLE cycle, l2_write=1, l2_address=0x4440, l2_wdata=0x0F..0F.
REQ-031 Both sides requesting continuously for 6 transactions -> grants alternate I,D,I,D,I,D; no resp is ever delivered to the non-granted side.
REQ-032 D read granted at 0x2000, then dcache_address changed to 0x3000 before l2_resp -> l2_address stays 0x2000 until resp.
REQ-033 reset_n=0 while in SERVE_D with l2_resp=1 -> dcache_resp still asserts combinationally in that cycle; next cycle l2_read=l2_write=0 and state IDLE; with both requests then pending, I is granted.
REQ-034 l2_resp pulsed in IDLE with no request pending -> no resp output and l2_read/l2_write remain 0.

Source files
------------

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing one L2 port between an I-cache line-fill port and a D-cache read/writeback port.
// A grant latches the winning request; the FSM then holds it until L2 completes and drops back to IDLE for one cycle.
module l2_arbiter (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         icache_read,
    input  logic [15:0]  icache_address,
    output logic [127:0] icache_rdata,
    output logic         icache_resp,
    input  logic         dcache_read,
    input  logic         dcache_write,
    input  logic [15:0]  dcache_address,
    input  logic [127:0] dcache_wdata,
    output logic [127:0] dcache_rdata,
    output logic         dcache_resp,
    output logic         l2_read,
    output logic         l2_write,
    output logic [15:0]  l2_address,
    output logic [127:0] l2_wdata,
    input  logic [127:0] l2_rdata,
    input  logic         l2_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    state_t       r_state;
    state_t       w_next_state;
    logic         r_last_grant;
    logic [15:0]  r_address;
    logic         r_write;
    logic [127:0] r_wdata;

    logic         w_i_req;
    logic         w_d_req;
    logic         w_grant_d;
    logic         w_grant;

    assign w_i_req = icache_read;
    assign w_d_req = dcache_read | dcache_write;

    // On a tie the side that did not win last time gets the slot.
    assign w_grant_d = w_d_req & (~w_i_req | (r_last_grant == SIDE_I));
    assign w_grant   = (r_state == IDLE) & (w_i_req | w_d_req);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
        w_next_state = r_state;
        l2_read      = 1'b0;
        l2_write     = 1'b0;
        l2_address   = '0;
        l2_wdata     = '0;
        icache_resp  = 1'b0;
        dcache_resp  = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_next_state = w_grant_d ? SERVE_D : SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                l2_read     = ~r_write;
                l2_write    = r_write;
                l2_address  = r_address;
                l2_wdata    = r_wdata;
                icache_resp = (r_state == SERVE_I) & l2_resp;
                dcache_resp = (r_state == SERVE_D) & l2_resp;
                if (l2_resp) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign icache_rdata = l2_rdata;
    assign dcache_rdata = l2_rdata;

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, and all state uses non-blocking assignment so every register sees pre-edge values.
        if (!reset_n) begin
            r_state      <= IDLE;
            r_last_grant <= SIDE_D;
            r_address    <= '0;
            r_write      <= 1'b0;
            r_wdata      <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_grant) begin
                r_last_grant <= w_grant_d;
                // Read+write together on the D side is illegal and resolves to a writeback.
                if (w_grant_d) begin
                    r_address <= dcache_address;
                    r_write   <= dcache_write;
                    r_wdata   <= dcache_wdata;
                end else begin
                    r_address <= icache_address;
                    r_write   <= 1'b0;
                    r_wdata   <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: directed reset/ordering scenarios, then randomized traffic whose expected L2 commands
// come from a transaction-level arbitration model and are checked by an independent monitor.
module tb_l2_arbiter;

    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    typedef struct {
        logic         side;
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
        int           start;
    } txn_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         icache_read;
    logic [15:0]  icache_address;
    logic [127:0] icache_rdata;
    logic         icache_resp;
    logic         dcache_read;
    logic         dcache_write;
    logic [15:0]  dcache_address;
    logic [127:0] dcache_wdata;
    logic [127:0] dcache_rdata;
    logic         dcache_resp;
    logic         l2_read;
    logic         l2_write;
    logic [15:0]  l2_address;
    logic [127:0] l2_wdata;
    logic [127:0] l2_rdata;
    logic         l2_resp;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_cnt = 0;

    txn_t exp_q[$];
    bit   mon_en = 1'b0;
    bit   prev_active;
    bit   have_cur;
    txn_t cur;

    bit   m_busy;
    logic m_owner;
    logic m_last;
    int   resp_at;
    bit   fin_i;
    bit   fin_d;

    l2_arbiter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .icache_read    (icache_read),
        .icache_address (icache_address),
        .icache_rdata   (icache_rdata),
        .icache_resp    (icache_resp),
        .dcache_read    (dcache_read),
        .dcache_write   (dcache_write),
        .dcache_address (dcache_address),
        .dcache_wdata   (dcache_wdata),
        .dcache_rdata   (dcache_rdata),
        .dcache_resp    (dcache_resp),
        .l2_read        (l2_read),
        .l2_write       (l2_write),
        .l2_address     (l2_address),
        .l2_wdata       (l2_wdata),
        .l2_rdata       (l2_rdata),
        .l2_resp        (l2_resp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic cycle();
        @(negedge clk);
        #2;
    endtask

    task automatic new_i();
        icache_read    = 1'b1;
        icache_address = 16'($urandom);
    endtask

    task automatic new_d();
        int r;
        r = $urandom_range(0, 9);
        dcache_read    = (r <= 4);
        dcache_write   = (r == 0) || (r >= 5);
        dcache_address = 16'($urandom);
        dcache_wdata   = rand128();
    endtask

    // One cycle of requester, L2 and arbitration-model behaviour, applied at the negative edge.
    task automatic drive_cycle(input bit allow_new);
        txn_t t;
        logic win;
        bit   d_req;

        if (fin_i) begin
            fin_i = 1'b0;
            if (allow_new && $urandom_range(0, 1) == 1) new_i();
            else icache_read = 1'b0;
        end else if (!icache_read) begin
            if (allow_new && !(m_busy && m_owner == SIDE_I) && $urandom_range(0, 3) == 0) new_i();
        end else if ($urandom_range(0, 3) == 0) begin
            if (m_busy && m_owner == SIDE_I && $urandom_range(0, 3) == 0) icache_read = 1'b0;
            else icache_address = 16'($urandom);
        end

        if (fin_d) begin
            fin_d = 1'b0;
            if (allow_new && $urandom_range(0, 1) == 1) new_d();
            else begin dcache_read = 1'b0; dcache_write = 1'b0; end
        end else if (!(dcache_read || dcache_write)) begin
            if (allow_new && !(m_busy && m_owner == SIDE_D) && $urandom_range(0, 3) == 0) new_d();
        end else if ($urandom_range(0, 3) == 0) begin
            if (m_busy && m_owner == SIDE_D && $urandom_range(0, 3) == 0) begin
                dcache_read  = 1'b0;
                dcache_write = 1'b0;
            end else begin
                dcache_address = 16'($urandom);
                dcache_wdata   = rand128();
            end
        end

        l2_rdata = rand128();
        l2_resp  = 1'b0;
        if (m_busy && cyc_cnt >= resp_at) l2_resp = 1'b1;
        else if (!m_busy && $urandom_range(0, 7) == 0) l2_resp = 1'b1;

        d_req = dcache_read || dcache_write;
        if (m_busy) begin
            if (l2_resp) begin
                m_busy = 1'b0;
                if (m_owner == SIDE_I) fin_i = 1'b1;
                else fin_d = 1'b1;
            end
        end else if (icache_read || d_req) begin
            if (icache_read && d_req) win = ~m_last;
            else win = d_req ? SIDE_D : SIDE_I;
            m_last  = win;
            m_owner = win;
            m_busy  = 1'b1;
            resp_at = cyc_cnt + 1 + int'($urandom_range(0, 3));
            t.side  = win;
            t.wr    = (win == SIDE_D) ? dcache_write : 1'b0;
            t.addr  = (win == SIDE_D) ? dcache_address : icache_address;
            t.wdata = (win == SIDE_D) ? dcache_wdata : '0;
            t.start = cyc_cnt + 1;
            exp_q.push_back(t);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (!mon_en) begin
            prev_active = 1'b0;
            have_cur    = 1'b0;
        end else begin
            check("rw_exclusive", {127'b0, l2_read && l2_write}, 128'd0);
            if ((l2_read || l2_write) && !prev_active) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_cmd", 128'd1, 128'd0);
                    have_cur = 1'b0;
                end else begin
                    cur      = exp_q.pop_front();
                    have_cur = 1'b1;
                    check("cmd_start_cycle", 128'(cyc_cnt), 128'(cur.start));
                    check("cmd_write", {127'b0, l2_write}, {127'b0, cur.wr});
                    check("cmd_addr", {112'b0, l2_address}, {112'b0, cur.addr});
                    check("cmd_wdata", l2_wdata, cur.wdata);
                end
            end else if ((l2_read || l2_write) && have_cur) begin
                check("hold_write", {127'b0, l2_write}, {127'b0, cur.wr});
                check("hold_addr", {112'b0, l2_address}, {112'b0, cur.addr});
                check("hold_wdata", l2_wdata, cur.wdata);
            end else if (!(l2_read || l2_write)) begin
                check("idle_addr", {112'b0, l2_address}, 128'd0);
                check("idle_wdata", l2_wdata, 128'd0);
            end
            check("i_resp", {127'b0, icache_resp},
                  {127'b0, l2_resp && (l2_read || l2_write) && have_cur && cur.side == SIDE_I});
            check("d_resp", {127'b0, dcache_resp},
                  {127'b0, l2_resp && (l2_read || l2_write) && have_cur && cur.side == SIDE_D});
            check("i_rdata", icache_rdata, l2_rdata);
            check("d_rdata", dcache_rdata, l2_rdata);
            prev_active = l2_read || l2_write;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b0;
        icache_read    = 1'b0;
        icache_address = '0;
        dcache_read    = 1'b0;
        dcache_write   = 1'b0;
        dcache_address = '0;
        dcache_wdata   = '0;
        l2_rdata       = '0;
        l2_resp        = 1'b0;
        cycle();
        cycle();
        check("rst_l2_read", {127'b0, l2_read}, 128'd0);
        check("rst_l2_write", {127'b0, l2_write}, 128'd0);
        check("rst_l2_address", {112'b0, l2_address}, 128'd0);

        // Single I fill with one-cycle arbitration latency and same-cycle response.
        reset_n        = 1'b1;
        icache_read    = 1'b1;
        icache_address = 16'h1230;
        cycle();
        check("i_fill_read", {127'b0, l2_read}, 128'd1);
        check("i_fill_addr", {112'b0, l2_address}, 128'h1230);
        l2_resp  = 1'b1;
        l2_rdata = {16{8'hA5}};
        #1;
        check("i_fill_resp", {127'b0, icache_resp}, 128'd1);
        check("i_fill_rdata", icache_rdata, {16{8'hA5}});
        check("i_fill_no_dresp", {127'b0, dcache_resp}, 128'd0);
        icache_read = 1'b0;
        cycle();
        l2_resp = 1'b0;
        check("i_fill_back_idle", {127'b0, l2_read}, 128'd0);

        // Stray L2 completion while idle.
        l2_resp = 1'b1;
        #1;
        check("idle_resp_i", {127'b0, icache_resp}, 128'd0);
        check("idle_resp_d", {127'b0, dcache_resp}, 128'd0);
        cycle();
        l2_resp = 1'b0;
        check("idle_resp_rw", {126'b0, l2_read, l2_write}, 128'd0);

        // Both pending out of reset: I first, then the D writeback after one idle cycle.
        reset_n = 1'b0;
        cycle();
        reset_n        = 1'b1;
        icache_read    = 1'b1;
        icache_address = 16'h0100;
        dcache_write   = 1'b1;
        dcache_address = 16'h4440;
        dcache_wdata   = {16{8'h0F}};
        cycle();
        check("both_i_first", {127'b0, l2_read}, 128'd1);
        check("both_i_addr", {112'b0, l2_address}, 128'h0100);
        l2_resp = 1'b1;
        #1;
        check("both_i_resp", {126'b0, icache_resp, dcache_resp}, 128'd2);
        icache_read = 1'b0;
        cycle();
        l2_resp = 1'b0;
        check("both_gap_idle", {126'b0, l2_read, l2_write}, 128'd0);
        cycle();
        check("both_d_write", {126'b0, l2_read, l2_write}, 128'd1);
        check("both_d_addr", {112'b0, l2_address}, 128'h4440);
        check("both_d_wdata", l2_wdata, {16{8'h0F}});
        l2_resp = 1'b1;
        #1;
        check("both_d_resp", {126'b0, icache_resp, dcache_resp}, 128'd1);
        dcache_write   = 1'b0;
        dcache_read    = 1'b1;
        dcache_address = 16'h2000;
        cycle();
        l2_resp = 1'b0;

        // Requester address change after grant is ignored.
        cycle();
        check("dread_addr", {112'b0, l2_address}, 128'h2000);
        dcache_address = 16'h3000;
        cycle();
        check("dread_addr_hold1", {112'b0, l2_address}, 128'h2000);
        cycle();
        check("dread_addr_hold2", {112'b0, l2_address}, 128'h2000);

        // Reset coincident with l2_resp in SERVE_D.
        l2_resp        = 1'b1;
        reset_n        = 1'b0;
        icache_read    = 1'b1;
        icache_address = 16'h0AA0;
        #1;
        check("rst_resp_dresp", {127'b0, dcache_resp}, 128'd1);
        cycle();
        l2_resp = 1'b0;
        reset_n = 1'b1;
        check("rst_resp_idle", {126'b0, l2_read, l2_write}, 128'd0);
        cycle();
        check("rst_resp_i_grant", {127'b0, l2_read}, 128'd1);
        check("rst_resp_i_addr", {112'b0, l2_address}, 128'h0AA0);

        // Continuous requests on both sides alternate I,D,I,D,I,D.
        reset_n     = 1'b0;
        dcache_read = 1'b0;
        icache_read = 1'b0;
        cycle();
        reset_n        = 1'b1;
        icache_read    = 1'b1;
        icache_address = 16'h0111;
        dcache_read    = 1'b1;
        dcache_address = 16'h0222;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("alt_addr", {112'b0, l2_address}, (k % 2 == 0) ? 128'h0111 : 128'h0222);
            l2_resp = 1'b1;
            #1;
            check("alt_resp", {126'b0, icache_resp, dcache_resp}, (k % 2 == 0) ? 128'd2 : 128'd1);
            cycle();
            l2_resp = 1'b0;
            check("alt_gap", {126'b0, l2_read, l2_write}, 128'd0);
        end

        // Randomized traffic checked by the monitor.
        reset_n     = 1'b0;
        icache_read = 1'b0;
        dcache_read = 1'b0;
        cycle();
        reset_n = 1'b1;
        m_busy  = 1'b0;
        m_owner = SIDE_I;
        m_last  = SIDE_D;
        resp_at = 0;
        fin_i   = 1'b0;
        fin_d   = 1'b0;
        mon_en  = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            drive_cycle(1'b1);
        end
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (!m_busy && !icache_read && !dcache_read && !dcache_write && !fin_i && !fin_d) break;
            drive_cycle(1'b0);
        end
        @(negedge clk);
        l2_resp = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        check("drain_busy", {127'b0, m_busy}, 128'd0);
        check("queue_drained", 128'(exp_q.size()), 128'd0);
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
